// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO result registers.
// One radix-2 step per cycle; signed ops run on magnitudes and are corrected in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE,
    S_DZERO
  } state_t;

  state_t             state;
  logic               is_div_q;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res;
  logic               neg_rem;
  logic [CW-1:0]      count;

  // Decode of the incoming request: op[1] selects divide, op[0]=0 selects signed.
  logic             in_div;
  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs_in;
  logic [WIDTH-1:0] b_abs_in;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_div    = op[1];
    in_signed = ~op[0];
    a_neg     = in_signed & operand_a[WIDTH-1];
    b_neg     = in_signed & operand_b[WIDTH-1];
    a_abs_in  = a_neg ? -operand_a : operand_a;
    b_abs_in  = b_neg ? -operand_b : operand_b;
  end

  // Multiply keeps {partial_high, multiplier} in acc and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_abs} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow flag.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_abs};
    if (div_trial[WIDTH])
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Signed correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      is_div_q <= 1'b0;
      b_abs    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (signal_start) begin
            is_div_q <= in_div;
            b_abs    <= b_abs_in;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= in_div & a_neg;
            count    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            if (in_div && operand_b == '0) begin
              // Raw dividend is kept so HI reports it unchanged.
              acc   <= {{WIDTH{1'b0}}, operand_a};
              state <= S_DZERO;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_abs_in};
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc   <= is_div_q ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DZERO: begin
          hi       <= acc[WIDTH-1:0];
          lo       <= '1;
          div_zero <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: hand-computed MULT/MULTU/DIV/DIVU results,
// latency, handshake and asynchronous reset behaviour.
module tb_mips_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .signal_start (signal_start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero)
  );

  always #5 clk = ~clk;

  // Starts one operation and waits for done. Optional start pulses at cycles p1/p2
  // (counted from E0) carry a conflicting divide-by-zero request.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int p1, input int p2, output int cyc);
    logic [31:0] hi0, lo0;
    bit seen;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; signal_start = 1'b1;
    hi0 = hi; lo0 = lo;
    @(posedge clk); #1;
    signal_start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (cyc == p1 || cyc == p2) begin
        op = OP_DIVU; operand_a = 32'h1; operand_b = 32'h0; signal_start = 1'b1;
      end
      @(posedge clk); #1;
      signal_start = 1'b0;
      cyc++;
      if (busy && done) begin
        checks++; errors++;
        $display("FAIL busy_done_overlap: cycle %0d busy=1 done=1", cyc);
      end
      if (done) seen = 1;
      else if (hi !== hi0 || lo !== lo0) begin
        checks++; errors++;
        $display("FAIL hilo_stable: cycle %0d hi=%h lo=%h required %h %h", cyc, hi, lo, hi0, lo0);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: after done busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic expect_result(input string name, input logic [31:0] e_hi,
                               input logic [31:0] e_lo, input logic e_dz);
    checks++;
    if (hi !== e_hi || lo !== e_lo || div_zero !== e_dz) begin
      errors++;
      $display("FAIL %s: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
               name, hi, lo, div_zero, e_hi, e_lo, e_dz);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
               hi, lo, busy, done, div_zero);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult();
    int cyc;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, cyc);
    expect_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL mult_latency: cycles=%0d required 33", cyc);
    end
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd6, -1, -1, cyc);
    expect_result("mult_neg_pos", 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, -1, -1, cyc);
    expect_result("mult_neg_neg", 32'h0, 32'd42, 1'b0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, -1, cyc);
    expect_result("mult_minmin", 32'h4000_0000, 32'h0, 1'b0);
    run_op(OP_MULT, 32'h0000_0003, 32'hFFFF_FFFF, -1, -1, cyc);
    expect_result("mult_pos_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_div();
    int cyc;
    run_op(OP_DIV, 32'hFFFF_FFEF, 32'd5, -1, -1, cyc);
    expect_result("div_neg", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL div_latency: cycles=%0d required 33", cyc);
    end
    run_op(OP_DIVU, 32'd17, 32'd5, -1, -1, cyc);
    expect_result("divu_basic", 32'd2, 32'd3, 1'b0);
    run_op(OP_DIV, 32'd17, 32'hFFFF_FFFB, -1, -1, cyc);
    expect_result("div_pos_neg", 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, -1, -1, cyc);
    expect_result("divu_big", 32'd0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_boundary();
    int cyc;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, cyc);
    expect_result("div_min_by_m1", 32'h0, 32'h8000_0000, 1'b0);
    run_op(OP_DIVU, 32'd9, 32'd0, -1, -1, cyc);
    expect_result("divu_zero", 32'd9, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL dzero_latency: cycles=%0d required 1", cyc);
    end
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, -1, -1, cyc);
    expect_result("div_zero_signed", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op(OP_DIVU, 32'd100, 32'd7, -1, -1, cyc);
    expect_result("div_zero_cleared", 32'd2, 32'd14, 1'b0);
  endtask

  task automatic test_start_ignored();
    int cyc;
    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 5, 20, cyc);
    expect_result("ignored_starts", 32'h0000_0001, 32'h2345_6780, 1'b0);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL ignored_latency: cycles=%0d required 33", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(OP_MULTU, 32'd1000, 32'd1000, -1, -1, cyc);
    expect_result("b2b_first", 32'h0, 32'd1000000, 1'b0);
    run_op(OP_DIVU, 32'd1000000, 32'd999, -1, -1, cyc);
    expect_result("b2b_second", 32'd1, 32'd1001, 1'b0);
  endtask

  task automatic test_reset_midop();
    int cyc;
    @(negedge clk);
    op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; signal_start = 1'b1;
    @(posedge clk); #1;
    signal_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, -1, -1, cyc);
    expect_result("after_reset", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_boundary();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
